// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state, fun3 encodings,
// request legality and store-lane formatting.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned variants exist only for loads; alignment follows the access size.
   function automatic logic access_ok(input logic       is_load,
                                      input logic [2:0] f3,
                                      input logic [1:0] a);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B:  ok = 1'b1;
         F3_BU: ok = is_load;
         F3_H:  ok = ~a[0];
         F3_HU: ok = is_load & ~a[0];
         F3_W:  ok = (a == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] store_mask(input logic [2:0] f3,
                                             input logic [1:0] a);
      logic [3:0] m;
      case (f3)
         F3_B:    m = 4'b0001 << a;
         F3_H:    m = a[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                               input logic [31:0] sd);
      logic [31:0] w;
      case (f3)
         F3_B:    w = {4{sd[7:0]}};
         F3_H:    w = {2{sd[15:0]}};
         default: w = sd;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: selects the addressed byte/halfword from the
// returned word and sign- or zero-extends it according to fun3.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [2:0]  fun3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = 8'(rdata >> {addr_lo, 3'b000});
   assign half_sel = 16'(rdata >> {addr_lo[1], 4'b0000});

   always_comb begin
      result = rdata;
      case (fun3)
         F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   result = {24'h0, byte_sel};
         F3_H:    result = {{16{half_sel[15]}}, half_sel};
         F3_HU:   result = {16'h0, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one valid/ready data-memory transaction per request and
// returns extended load data. Optional request timeout enabled by LSU_TIMEOUT_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        store,
   input  logic [2:0]  fun3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        req_valid,
   input  logic        req_ready,
   output logic        req_we,
   output logic [31:0] req_addr,
   output logic [31:0] req_wdata,
   output logic [3:0]  req_wmask,
   input  logic        resp_valid,
   input  logic [31:0] resp_rdata,
   output logic        valid,
   output logic        load_control,
   output logic [31:0] load_data,
   output logic        err
);

   lsu_state_t  state, state_nxt;
   logic        is_load_q;
   logic [2:0]  fun3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wmask_q;
   logic [31:0] load_data_q;
   logic [31:0] aligned;
   logic        err_q, err_nxt;
   logic        start, start_ok;
   logic        tmo_hit;

   assign start    = load | store;
   assign start_ok = access_ok(load, fun3, addr[1:0]);

`ifdef LSU_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state != REQ && state_nxt == REQ) begin
         tmo_cnt <= '0;
      end else if (state == REQ || state == WAIT) begin
         tmo_cnt <= tmo_cnt + 8'd1;
      end
   end

   // Fires in the last allowed cycle so the abort lands after TIMEOUT_CYCLES cycles.
   assign tmo_hit = (state == REQ || state == WAIT) &&
                    (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         err_q <= err_nxt;
      end
   end

   // Load wins when both requests are high; store lanes are formatted up front.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_load_q <= 1'b0;
         fun3_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wmask_q   <= '0;
      end else if (state == IDLE && start) begin
         is_load_q <= load;
         fun3_q    <= fun3;
         addr_q    <= addr;
         wdata_q   <= load ? 32'h0 : store_lanes(fun3, store_data);
         wmask_q   <= load ? 4'h0  : store_mask(fun3, addr[1:0]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_data_q <= '0;
      end else if (state == WAIT && resp_valid) begin
         load_data_q <= aligned;
      end
   end

   // NOTE: every combinational output gets a default first so no path
   // through the case leaves a signal unassigned (no inferred latch).
   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (start_ok) state_nxt = REQ;
               else          err_nxt   = 1'b1;
            end
         end
         REQ: begin
            if (req_ready) begin
               state_nxt = is_load_q ? WAIT : IDLE;
            end else if (tmo_hit) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end
         end
         WAIT: begin
            if (resp_valid) begin
               state_nxt = DONE;
            end else if (tmo_hit) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   lsu_load_align u_align (
      .fun3    (fun3_q),
      .addr_lo (addr_q[1:0]),
      .rdata   (resp_rdata),
      .result  (aligned)
   );

   // Request fields are gated by state so they fall with reset asynchronously.
   assign req_valid    = (state == REQ);
   assign req_we       = req_valid & ~is_load_q;
   assign req_addr     = req_valid ? {addr_q[31:2], 2'b00} : 32'h0;
   assign req_wdata    = req_valid ? wdata_q : 32'h0;
   assign req_wmask    = req_valid ? wmask_q : 4'h0;
   assign valid        = (state == REQ) || (state == WAIT);
   assign load_control = (state == DONE);
   assign load_data    = load_data_q;
   assign err          = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected memory requests, load results
// and error pulses are queued by the driver and matched by a negedge monitor.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        load, store;
   logic [2:0]  fun3;
   logic [31:0] addr, store_data;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wmask;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        valid, load_control, err;
   logic [31:0] load_data;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .store        (store),
      .fun3         (fun3),
      .addr         (addr),
      .store_data   (store_data),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_wmask    (req_wmask),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .valid        (valid),
      .load_control (load_control),
      .load_data    (load_data),
      .err          (err)
   );

   typedef enum int {EV_REQ, EV_LOAD, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] data;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic ev_t mk(input ev_kind_t k, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] d);
      ev_t e;
      e.kind = k; e.we = we; e.addr = a; e.wdata = wd; e.wmask = wm; e.data = d;
      return e;
   endfunction

   task automatic expect_event(input ev_kind_t k, output ev_t e, output bit ok);
      n_checks++;
      ok = 1'b0;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL event_order: got %s with nothing expected", k.name());
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k) begin
            n_fail++;
            $display("FAIL event_order: got %s expected %s", k.name(), e.kind.name());
         end else begin
            ok = 1'b1;
         end
      end
   endtask

   // Monitor: any observable DUT event must match the head of the queue.
   always @(negedge clk) begin
      ev_t e;
      bit  ok;
      if (!rst) begin
         if (req_valid && req_ready) begin
            expect_event(EV_REQ, e, ok);
            if (ok) begin
               check("req_we",    32'(req_we),    32'(e.we));
               check("req_addr",  req_addr,       e.addr);
               check("req_wdata", req_wdata,      e.wdata);
               check("req_wmask", 32'(req_wmask), 32'(e.wmask));
            end
         end
         if (load_control) begin
            expect_event(EV_LOAD, e, ok);
            if (ok) check("load_data", load_data, e.data);
         end
         if (err) expect_event(EV_ERR, e, ok);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
      load = ld; store = st; fun3 = f3; addr = a; store_data = sd;
      tick();
      load = 1'b0; store = 1'b0;
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input int ready_dly,
                          input int resp_dly, input logic [31:0] rdata, input logic [31:0] exp);
      exp_q.push_back(mk(EV_REQ, 1'b0, {a[31:2], 2'b00}, 32'h0, 4'h0, 32'h0));
      exp_q.push_back(mk(EV_LOAD, 1'b0, 32'h0, 32'h0, 4'h0, exp));
      issue(1'b1, 1'b0, f3, a, 32'h0);
      check("valid_in_req", 32'(valid), 32'd1);
      repeat (ready_dly) tick();
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      check("valid_in_wait", 32'(valid), 32'd1);
      check("req_valid_in_wait", 32'(req_valid), 32'd0);
      repeat (resp_dly) tick();
      resp_valid = 1'b1; resp_rdata = rdata;
      tick();
      resp_valid = 1'b0;
      check("lc_in_done", 32'(load_control), 32'd1);
      check("valid_in_done", 32'(valid), 32'd0);
      tick();
      check("lc_after_done", 32'(load_control), 32'd0);
      check("load_data_held", load_data, exp);
   endtask

   task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                           input logic [3:0] mask, input logic [31:0] wdata, input int ready_dly);
      exp_q.push_back(mk(EV_REQ, 1'b1, {a[31:2], 2'b00}, wdata, mask, 32'h0));
      issue(1'b0, 1'b1, f3, a, sd);
      repeat (ready_dly) tick();
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      check("valid_after_store", 32'(valid), 32'd0);
      tick();
      check("lc_after_store", 32'(load_control), 32'd0);
   endtask

   task automatic do_err(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a);
      exp_q.push_back(mk(EV_ERR, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0));
      issue(ld, st, f3, a, 32'h1234ABCD);
      check("err_pulse", 32'(err), 32'd1);
      check("err_no_req", 32'(req_valid), 32'd0);
      check("err_not_busy", 32'(valid), 32'd0);
      tick();
      check("err_one_cycle", 32'(err), 32'd0);
      check("err_still_no_req", 32'(req_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; load = 1'b0; store = 1'b0; fun3 = 3'b000; addr = 32'h0; store_data = 32'h0;
      req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 32'h0;
      repeat (2) tick();
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_valid",     32'(valid),     32'd0);
      check("rst_lc",        32'(load_control), 32'd0);
      check("rst_err",       32'(err),       32'd0);
      check("rst_load_data", load_data,      32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Word load, immediate accept, response two cycles later
      do_load(3'b010, 32'h100, 0, 2, 32'hDEADBEEF, 32'hDEADBEEF);

      // Byte/halfword extraction and extension
      do_load(3'b000, 32'h103, 0, 0, 32'h80FF0000, 32'hFFFFFF80);
      do_load(3'b100, 32'h103, 1, 0, 32'h80FF0000, 32'h00000080);
      do_load(3'b101, 32'h102, 0, 1, 32'h80FF0000, 32'h000080FF);
      do_load(3'b001, 32'h102, 0, 0, 32'h80FF0000, 32'hFFFF80FF);
      do_load(3'b000, 32'h101, 0, 0, 32'h80FF0000, 32'h00000000);

      // Stores
      do_store(3'b001, 32'h202, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 0);
      do_store(3'b000, 32'h001, 32'h1234ABCD, 4'b0010, 32'hCDCDCDCD, 1);
      do_store(3'b010, 32'h300, 32'h1234ABCD, 4'b1111, 32'h1234ABCD, 0);

      // Illegal or misaligned requests
      do_err(1'b1, 1'b0, 3'b010, 32'h101);
      do_err(1'b1, 1'b0, 3'b011, 32'h100);
      do_err(1'b0, 1'b1, 3'b100, 32'h100);
      do_err(1'b0, 1'b1, 3'b001, 32'h203);
      check("load_data_after_err", load_data, 32'h00000000);

      // Stall for three cycles, then reset while waiting for the response
      exp_q.push_back(mk(EV_REQ, 1'b0, 32'h80, 32'h0, 4'h0, 32'h0));
      issue(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
      for (int i = 0; i < 3; i++) begin
         check("stall_req_valid", 32'(req_valid), 32'd1);
         check("stall_req_addr",  req_addr,       32'h80);
         check("stall_req_we",    32'(req_we),    32'd0);
         check("stall_req_wmask", 32'(req_wmask), 32'd0);
         check("stall_valid",     32'(valid),     32'd1);
         tick();
      end
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      tick();
      check("wait_before_rst", 32'(valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid",     32'(valid),     32'd0);
      check("async_rst_req_valid", 32'(req_valid), 32'd0);
      check("async_rst_req_addr",  req_addr,       32'h0);
      check("async_rst_lc",        32'(load_control), 32'd0);
      check("async_rst_load_data", load_data,      32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      do_load(3'b010, 32'h40, 0, 0, 32'h0BADF00D, 32'h0BADF00D);

      // Memory that never accepts
`ifdef LSU_TIMEOUT_EN
      exp_q.push_back(mk(EV_ERR, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0));
      issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      repeat (7) tick();
      check("tmo_last_busy_cycle", 32'(valid), 32'd1);
      tick();
      check("tmo_err",       32'(err),       32'd1);
      check("tmo_valid",     32'(valid),     32'd0);
      check("tmo_req_valid", 32'(req_valid), 32'd0);
      tick();
      check("tmo_err_pulse", 32'(err), 32'd0);
      check("tmo_load_data", load_data, 32'h0BADF00D);
`else
      issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      for (int i = 0; i < 4; i++) begin
         repeat (5) tick();
         check("no_tmo_valid", 32'(valid), 32'd1);
         check("no_tmo_err",   32'(err),   32'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("recover_valid", 32'(valid), 32'd0);
`endif

      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
